// File: rtl/arb_pkg.sv
// Shared types and memory access-mode encodings for the unified-memory arbiter.
package arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} arb_state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;
endpackage

// File: rtl/arb_prio_sel.sv
// Picks one requester: data first, unless fetch has been starved long enough.
module arb_prio_sel (
  input  logic if_req,
  input  logic d_req,
  input  logic starve_full,
  output logic grant_i,
  output logic grant_d
);
  assign grant_d = d_req & (~if_req | ~starve_full);
  assign grant_i = if_req & (~d_req | starve_full);
endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int STARVE_N = 2,
  parameter int TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_mode,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_mode,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);
  localparam int SW = $clog2(STARVE_N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          we_q, we_d;
  logic          grant_i, grant_d, starve_full, tmo_hit;
  owner_t        owner;

  assign starve_full = (starve_q == SW'(STARVE_N));
  assign tmo_hit     = (tmo_q == TW'(TIMEOUT - 1));
  assign owner       = (state_q == BUSY_D) ? OWN_D : OWN_I;

  arb_prio_sel u_sel (
    .if_req     (if_req),
    .d_req      (d_req),
    .starve_full(starve_full),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    tmo_d     = tmo_q;
    we_d      = we_q;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mode  = '0;
    err       = 1'b0;
    // Everything is suppressed during reset so an in-flight access dies silently.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            if_gnt   = 1'b1;
            mem_req  = 1'b1;
            mem_addr = if_addr;
            mem_mode = MODE_W;
            state_d  = BUSY_I;
            tmo_d    = '0;
            we_d     = 1'b0;
            starve_d = '0;
          end else if (grant_d) begin
            d_gnt     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_mode  = d_mode;
            state_d   = BUSY_D;
            tmo_d     = '0;
            we_d      = d_we;
            if (if_req && !starve_full) starve_d = starve_q + SW'(1);
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_rvalid || tmo_hit) begin
            // A response arriving on the timeout cycle still counts as success.
            err     = ~mem_rvalid;
            state_d = IDLE;
            if (owner == OWN_D) begin
              d_rvalid = 1'b1;
              d_rdata  = (mem_rvalid && !we_q) ? mem_rdata : '0;
            end else begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rvalid ? mem_rdata : '0;
            end
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      tmo_q    <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
      we_q     <= we_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants, responses, starvation, timeout, reset abort.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_mode, mem_mode;
  logic        mem_req, mem_we, mem_rvalid, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_N(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mode(d_mode),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mode(mem_mode), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
    chk({tag, ".d_rvalid"},  {31'd0, d_rvalid},  32'd0);
    chk({tag, ".err"},       {31'd0, err},       32'd0);
  endtask

  initial begin
    logic exp_d [6];
    exp_d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_mode = 0; mem_rvalid = 0; mem_rdata = 0;
    cyc(); cyc();
    smp();
    chk("rst.outputs", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, err, 25'd0}, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);

    // 1: stray mem_rvalid in IDLE
    cyc(); rst = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA5555;
    smp(); chk_quiet("stray");
    chk("stray.if_rdata", if_rdata, 32'd0);

    // 2: fetch, latency 1
    cyc(); mem_rvalid = 0; if_req = 1; if_addr = 32'h10;
    smp();
    chk("fetch.if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("fetch.mem_req", {31'd0, mem_req}, 32'd1);
    chk("fetch.mem_addr", mem_addr, 32'h10);
    chk("fetch.mem_mode", {29'd0, mem_mode}, 32'd2);
    cyc(); if_req = 0; mem_rvalid = 1; mem_rdata = 32'h00500093;
    smp();
    chk("fetch.if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("fetch.if_rdata", if_rdata, 32'h00500093);
    chk("fetch.d_rvalid", {31'd0, d_rvalid}, 32'd0);

    // 3: store, latency 2
    cyc(); mem_rvalid = 0; d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_mode = 3'b000;
    smp();
    chk("store.d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("store.mem_we", {31'd0, mem_we}, 32'd1);
    chk("store.mem_addr", mem_addr, 32'h40);
    chk("store.mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("store.mem_mode", {29'd0, mem_mode}, 32'd0);
    cyc(); d_req = 0; d_we = 0;
    smp(); chk_quiet("store.wait");
    chk("store.mem_req_busy", {31'd0, mem_req}, 32'd0);
    cyc(); mem_rvalid = 1; mem_rdata = 32'h12345678;
    smp();
    chk("store.d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("store.d_rdata", d_rdata, 32'd0);
    chk("store.err", {31'd0, err}, 32'd0);

    // 4: both held, expect D D I D D I
    cyc(); mem_rvalid = 0; if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0;
    d_addr = 32'h200; d_mode = 3'b010;
    for (int g = 0; g < 6; g++) begin
      smp();
      chk($sformatf("starve%0d.d_gnt", g), {31'd0, d_gnt}, {31'd0, exp_d[g]});
      chk($sformatf("starve%0d.if_gnt", g), {31'd0, if_gnt}, {31'd0, ~exp_d[g]});
      cyc(); mem_rvalid = 1; mem_rdata = 32'hC0DE0000 + g;
      smp();
      chk($sformatf("starve%0d.busy_gnt", g), {30'd0, if_gnt, d_gnt}, 32'd0);
      chk($sformatf("starve%0d.rvalid", g), {30'd0, d_rvalid, if_rvalid},
          exp_d[g] ? 32'd2 : 32'd1);
      chk($sformatf("starve%0d.rdata", g), exp_d[g] ? d_rdata : if_rdata, 32'hC0DE0000 + g);
      cyc(); mem_rvalid = 0;
    end

    // 5: timeout on a load
    if_req = 0; d_req = 1; d_we = 0; d_addr = 32'h80;
    smp(); chk("tmo.d_gnt", {31'd0, d_gnt}, 32'd1);
    cyc(); d_req = 0; mem_rdata = 32'hFFFF0000;
    for (int k = 1; k < 16; k++) begin
      smp();
      chk($sformatf("tmo.wait%0d", k), {30'd0, d_rvalid, err}, 32'd0);
      cyc();
    end
    smp();
    chk("tmo.d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("tmo.err", {31'd0, err}, 32'd1);
    chk("tmo.d_rdata", d_rdata, 32'd0);
    cyc(); mem_rvalid = 1; if_req = 1; if_addr = 32'h44;
    smp(); chk_quiet("tmo.late");
    chk("tmo.idle_if_gnt", {31'd0, if_gnt}, 32'd1);
    cyc(); if_req = 0; mem_rvalid = 1; mem_rdata = 32'h13;
    smp();
    chk("tmo.next_if_rdata", if_rdata, 32'h13);
    chk("tmo.next_err", {31'd0, err}, 32'd0);

    // 6: reset while BUSY_D
    cyc(); mem_rvalid = 0; d_req = 1; d_we = 0; d_addr = 32'h90;
    smp(); chk("rstb.d_gnt", {31'd0, d_gnt}, 32'd1);
    cyc(); d_req = 0; rst = 1; mem_rvalid = 1; mem_rdata = 32'h77;
    smp(); chk_quiet("rstb.in_rst");
    cyc(); rst = 0; mem_rvalid = 1; mem_rdata = 32'h88; if_req = 1; if_addr = 32'h20;
    smp(); chk_quiet("rstb.dropped");
    chk("rstb.if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("rstb.mem_addr", mem_addr, 32'h20);
    cyc(); if_req = 0; mem_rvalid = 1; mem_rdata = 32'h99;
    smp();
    chk("rstb.if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("rstb.if_rdata", if_rdata, 32'h99);
    cyc(); mem_rvalid = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
